// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised Moore serial pattern detector with runtime-loadable pattern
// Optional Mealy early-match output z_early is enabled by defining SEQDET_MEALY_OUT_EN.
module seq_detector_param #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
   parameter bit               OVERLAP = 1'b1,
   parameter int               CNT_W   = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         x,
   input  logic                         en,
   input  logic                         pat_load,
   input  logic [PAT_W-1:0]             pat_in,
   output logic [$clog2(PAT_W+1)-1:0]   state,
   output logic                         z,
   output logic [CNT_W-1:0]             match_cnt,
   output logic                         cnt_sat
`ifdef SEQDET_MEALY_OUT_EN
   ,
   output logic                         z_early
`endif
);

   localparam int SW = $clog2(PAT_W+1);
   localparam logic [SW-1:0]  FULL = SW'(PAT_W);
   localparam logic [PAT_W:0] ONE  = (PAT_W+1)'(1);

   logic [PAT_W-1:0] pat_q, pat_d;
   logic [SW-1:0]    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;

   logic [SW-1:0]    s_eff;
   logic [PAT_W:0]   hist;
   logic [PAT_W:0]   mask;
   logic [SW-1:0]    next_state;

   // The last s_eff accepted bits are by definition the pattern prefix of that
   // length, so the history needed for the fallback is rebuilt from pat_q.
   always_comb begin
      s_eff = state_q;
      if ((state_q == FULL) && !OVERLAP) begin
         s_eff = '0;
      end
      hist       = {(pat_q >> (FULL - s_eff)), x};
      mask       = '0;
      next_state = '0;
      // Ascending scan: the longest prefix that is also a suffix wins.
      for (int k = 1; k <= PAT_W; k++) begin
         mask = (ONE << k) - ONE;
         if ((k <= int'(s_eff) + 1) &&
             ((hist & mask) == {1'b0, (pat_q >> (PAT_W - k))})) begin
            next_state = SW'(k);
         end
      end
   end

   always_comb begin
      pat_d   = pat_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      if (pat_load) begin
         pat_d   = pat_in;
         state_d = '0;
      end else if (en) begin
         state_d = next_state;
         if ((next_state == FULL) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      if (cnt_d == '1) begin
         sat_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pat_q   <= PATTERN;
         state_q <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         pat_q   <= pat_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
      end
   end

   assign state     = state_q;
   assign z         = (state_q == FULL);
   assign match_cnt = cnt_q;
   assign cnt_sat   = sat_q;

`ifdef SEQDET_MEALY_OUT_EN
   assign z_early = en & ~pat_load & ~reset & (next_state == FULL);
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param (overlap, non-overlap, narrow counter)
module tb_seq_detector_param;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       x = 1'b0;
   logic       en = 1'b0;
   logic       pat_load = 1'b0;
   logic [3:0] pat_in = 4'b0000;

   always #5 clk = ~clk;

   logic [2:0] state_a, state_b, state_c;
   logic       z_a, z_b, z_c;
   logic [7:0] cnt_a, cnt_b;
   logic [1:0] cnt_c;
   logic       sat_a, sat_b, sat_c;
`ifdef SEQDET_MEALY_OUT_EN
   logic       ze_a, ze_b, ze_c;
`endif

   seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
      .clk(clk), .reset(reset), .x(x), .en(en), .pat_load(pat_load), .pat_in(pat_in),
      .state(state_a), .z(z_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
`ifdef SEQDET_MEALY_OUT_EN
      , .z_early(ze_a)
`endif
   );

   seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
      .clk(clk), .reset(reset), .x(x), .en(en), .pat_load(pat_load), .pat_in(pat_in),
      .state(state_b), .z(z_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
`ifdef SEQDET_MEALY_OUT_EN
      , .z_early(ze_b)
`endif
   );

   seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
      .clk(clk), .reset(reset), .x(x), .en(en), .pat_load(pat_load), .pat_in(pat_in),
      .state(state_c), .z(z_c), .match_cnt(cnt_c), .cnt_sat(sat_c)
`ifdef SEQDET_MEALY_OUT_EN
      , .z_early(ze_c)
`endif
   );

   typedef struct packed {
      logic [2:0] st;
      logic       z;
      logic [7:0] cnt;
      logic       sat;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int errors = 0;
   int checks = 0;

   // Reference model: the accepted stream itself, newest bit at index 0.
   logic [3:0]  m_pat = 4'b1101;
   logic [15:0] m_hist [3];
   int          m_len  [3];
   int          m_st   [3];
   int          m_cnt  [3];
   logic        m_sat  [3];
   int          ov     [3] = '{1, 0, 1};
   int          cmax   [3] = '{255, 255, 3};

   function automatic int longest(input logic [15:0] h, input int len, input logic [3:0] p);
      int best = 0;
      for (int k = 1; k <= 4; k++) begin
         if (k <= len) begin
            bit ok = 1'b1;
            for (int i = 0; i < k; i++) begin
               if (h[k-1-i] != p[3-i]) ok = 1'b0;
            end
            if (ok) best = k;
         end
      end
      return best;
   endfunction

   task automatic model_step(input logic r, input logic e, input logic xb,
                             input logic pl, input logic [3:0] pi);
      exp_t ev;
      for (int d = 0; d < 3; d++) begin
         if (r) begin
            m_hist[d] = '0; m_len[d] = 0; m_st[d] = 0; m_cnt[d] = 0; m_sat[d] = 1'b0;
         end else if (pl) begin
            m_len[d] = 0; m_st[d] = 0;
         end else if (e) begin
            m_hist[d] = {m_hist[d][14:0], xb};
            if (m_len[d] < 16) m_len[d]++;
            m_st[d] = longest(m_hist[d], m_len[d], m_pat);
            if (m_st[d] == 4) begin
               if (m_cnt[d] < cmax[d]) m_cnt[d]++;
               if (m_cnt[d] == cmax[d]) m_sat[d] = 1'b1;
               if (ov[d] == 0) m_len[d] = 0;
            end
         end
         ev.st  = 3'(m_st[d]);
         ev.z   = (m_st[d] == 4);
         ev.cnt = 8'(m_cnt[d]);
         ev.sat = m_sat[d];
         case (d)
            0: q0.push_back(ev);
            1: q1.push_back(ev);
            default: q2.push_back(ev);
         endcase
      end
      if (r) m_pat = 4'b1101;
      else if (pl) m_pat = pi;
   endtask

   task automatic cmp(input string n, input exp_t e, input logic [2:0] st,
                      input logic zz, input logic [7:0] c, input logic s);
      checks++;
      if (st !== e.st) begin errors++; $display("FAIL %s.state got %0d want %0d t=%0t", n, st, e.st, $time); end
      checks++;
      if (zz !== e.z) begin errors++; $display("FAIL %s.z got %0b want %0b t=%0t", n, zz, e.z, $time); end
      checks++;
      if (c !== e.cnt) begin errors++; $display("FAIL %s.match_cnt got %0d want %0d t=%0t", n, c, e.cnt, $time); end
      checks++;
      if (s !== e.sat) begin errors++; $display("FAIL %s.cnt_sat got %0b want %0b t=%0t", n, s, e.sat, $time); end
   endtask

   exp_t e_m;
   always @(posedge clk) begin
      #1;
      if (q0.size() > 0) begin e_m = q0.pop_front(); cmp("a", e_m, state_a, z_a, cnt_a, sat_a); end
      if (q1.size() > 0) begin e_m = q1.pop_front(); cmp("b", e_m, state_b, z_b, cnt_b, sat_b); end
      if (q2.size() > 0) begin e_m = q2.pop_front(); cmp("c", e_m, state_c, z_c, {6'b0, cnt_c}, sat_c); end
   end

   task automatic cyc(input logic r, input logic e, input logic xb,
                      input logic pl, input logic [3:0] pi);
      @(negedge clk);
      reset = r; en = e; x = xb; pat_load = pl; pat_in = pi;
      model_step(r, e, xb, pl, pi);
   endtask

   task automatic feed(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) cyc(1'b0, 1'b1, bits[i], 1'b0, 4'b0000);
   endtask

   // Directed check of a fixed expectation once the pending edge has taken effect.
   task automatic settle;
      @(posedge clk);
      #2;
   endtask

   task automatic dcheck(input string n, input int act, input int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d t=%0t", n, act, want, $time);
      end
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         m_hist[d] = '0; m_len[d] = 0; m_st[d] = 0; m_cnt[d] = 0; m_sat[d] = 1'b0;
      end

      cyc(1, 0, 0, 0, 4'b0000);
      cyc(1, 0, 0, 0, 4'b0000);
      settle;
      dcheck("reset_state", int'(state_a), 0);
      dcheck("reset_cnt", int'(cnt_a), 0);
      repeat (8) cyc(0, 1, 0, 0, 4'b0000);

      // Default pattern stream, overlap (a) vs non-overlap (b)
      feed(32'b11101, 5);
      settle;
      dcheck("t1_z_a_bit5", int'(z_a), 1);
      dcheck("t1_z_b_bit5", int'(z_b), 1);
      feed(32'b101, 3);
      settle;
      dcheck("t1_state_a_bit8", int'(state_a), 4);
      dcheck("t1_state_b_bit8", int'(state_b), 1);
      feed(32'b111101010, 9);
      settle;
      dcheck("t1_cnt_a", int'(cnt_a), 3);
      dcheck("t1_cnt_b", int'(cnt_b), 2);

      // Border fallback with a self-overlapping pattern
      cyc(0, 1, 1, 1, 4'b1010);
      feed(32'b101010, 6);
      settle;
      dcheck("t3_state_a", int'(state_a), 4);
      dcheck("t3_state_b", int'(state_b), 2);
      dcheck("t3_cnt_a", int'(cnt_a), 5);
      dcheck("t3_cnt_b", int'(cnt_b), 3);

      // Enable gating holds progress
      cyc(1, 0, 0, 0, 4'b0000);
      feed(32'b11, 2);
      cyc(0, 0, 1, 0, 4'b0000);
      cyc(0, 0, 0, 0, 4'b0000);
      cyc(0, 0, 1, 0, 4'b0000);
      settle;
      dcheck("t4_state_gap", int'(state_a), 2);
      feed(32'b01, 2);
      settle;
      dcheck("t4_z", int'(z_a), 1);
      dcheck("t4_cnt", int'(cnt_a), 1);

      // Reset and load in the middle of a partial match
      feed(32'b110, 3);
      settle;
      dcheck("t5_state3", int'(state_b), 3);
      cyc(1, 1, 1, 1, 4'b0000);
      settle;
      dcheck("t5_reset_state", int'(state_a), 0);
      dcheck("t5_reset_cnt", int'(cnt_a), 0);
      feed(32'b1101110, 7);
      cyc(0, 1, 1, 1, 4'b1101);
      settle;
      dcheck("t5_load_state", int'(state_a), 0);
      dcheck("t5_load_cnt", int'(cnt_a), 1);

      // Counter saturation
      cyc(1, 0, 0, 0, 4'b0000);
      feed(32'b11011101110111011101, 20);
      settle;
      dcheck("t6_cnt_c", int'(cnt_c), 3);
      dcheck("t6_sat_c", int'(sat_c), 1);
      dcheck("t6_cnt_a", int'(cnt_a), 5);
      dcheck("t6_sat_a", int'(sat_a), 0);

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         cyc(($urandom % 100) == 0, ($urandom % 4) != 0, 1'($urandom),
             ($urandom % 40) == 0, 4'($urandom));
      end
      cyc(0, 0, 0, 0, 4'b0000);
      repeat (2) @(negedge clk);

      checks++;
      if ((q0.size() + q1.size() + q2.size()) != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d left want 0", q0.size() + q1.size() + q2.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
